controller_poller: RTL
======================

CONTROLLER_POLLER -- requirements
Module: controller_poller

Interface
REQ-001 Parameter CLKS_PER_US, default 50; clock cycles per 1 us protocol unit.
REQ-002 Parameter POLL_INTERVAL, default 833333; cycles from the end of one transaction to the start of the next (~60 Hz at 50 MHz).
REQ-003 Parameter TIMEOUT_US, default 8; maximum wait, in us, for the next falling edge while receiving.
REQ-004 clock  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high; one clock, synchronous active-high reset.
REQ-006 data_in  input  1  raw controller data line from a gpio pin; asynchronous to clock.
REQ-007 drive_low  output  1  1 = pull data line low (open-drain enable); 0 = release.
REQ-008 buttons  output  32  last valid controller response, first received bit in bit 31; feeds mmio p1Controller/p2Controller.
REQ-009 valid  output  1  one-cycle pulse when buttons is updated.
REQ-010 connected  output  1  1 = most recent transaction completed without timeout.

Function
REQ-011 data_in SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized value; falling edge = previous synchronized sample 1, current 0.
REQ-012 Bit encoding, unit U = CLKS_PER_US cycles: '0' = 3U low then 1U released; '1' = 1U low then 3U released; bit time 4U.
REQ-013 FSM states: IDLE, TX, WAIT_RX, RX, STOP.
REQ-014 IDLE: counter increments each cycle; at POLL_INTERVAL-1 SHALL go to TX, counter cleared; drive_low=0.
REQ-015 TX: SHALL send command 0x01 MSB first (8 bits, 32U), then stop bit = 1U low, 2U released; total 35U; drive_low follows REQ-012 exactly to the cycle.
REQ-016 After the stop bit the FSM SHALL enter WAIT_RX with drive_low=0 for the rest of the transaction.
REQ-017 WAIT_RX: falling edge -> RX, bit 0 begins; no falling edge within TIMEOUT_US*U cycles -> IDLE with connected=0, buttons unchanged, no valid pulse.
REQ-018 RX: each bit SHALL be sampled exactly 2U cycles after its falling edge; sample 1 -> bit '1', 0 -> bit '0'; bits shifted into a 32-bit shift register MSB first.
REQ-019 RX: after each sample, wait for the next falling edge; none within TIMEOUT_US*U cycles of the previous edge -> IDLE, connected=0, partial data discarded.
REQ-020 After bit 31 is sampled: STOP; the controller stop bit is ignored; STOP lasts 2U cycles, then buttons <= shift register, valid=1 for exactly that cycle, connected=1, -> IDLE.
REQ-021 Falling edges seen in IDLE or TX SHALL be ignored.
REQ-022 buttons SHALL change only at the REQ-020 commit; all other outputs are registered.
REQ-023 Counters SHALL be wide enough for POLL_INTERVAL and TIMEOUT_US*CLKS_PER_US without wrap.

Reset
REQ-024 While reset=1 on a rising edge: state=IDLE, all counters=0, shift register=0, synchronizer=1,1, drive_low=0, buttons=0, valid=0, connected=0.
REQ-025 Reset asserted mid-TX or mid-RX SHALL abort: drive_low=0 the next cycle, no valid pulse, buttons=0.
REQ-026 After reset release the first TX SHALL start exactly POLL_INTERVAL cycles later.

Verification (bench params CLKS_PER_US=4, POLL_INTERVAL=200, TIMEOUT_US=8)
REQ-027 Reset release, line idle high -> drive_low=0 for 200 cycles, then pattern 0,0,0,0,0,0,0,1 + stop: 7x(12 low/4 high), 4 low/12 high, stop 4 low/8 high.
REQ-028 Model replies 32'h8000_00FF 8 cycles after stop -> buttons=32'h800000FF, one-cycle valid, connected=1; second poll follows 200 cycles after commit.
REQ-029 No reply -> 32 cycles after stop: IDLE, connected=0, no valid, buttons hold prior value.
REQ-030 Model stops after 20 bits -> timeout 32 cycles after 20th edge, connected=0, buttons unchanged, next poll 200 cycles later.
REQ-031 Reset pulse during bit 10 of RX -> drive_low=0, buttons=0, connected=0, no valid; next TX 200 cycles after release.
REQ-032 Glitch edges on data_in during IDLE/TX -> no change to state, timing or outputs.

Source files
------------

// File: rtl/controller_poller.sv
// controller_poller: periodically polls a one-wire game controller and latches its 32-bit button word
module controller_poller #(
    parameter int CLKS_PER_US   = 50,
    parameter int POLL_INTERVAL = 833333,
    parameter int TIMEOUT_US    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_in,
    output logic        drive_low,
    output logic [31:0] buttons,
    output logic        valid,
    output logic        connected
);
    localparam int U  = CLKS_PER_US;
    localparam int TO = TIMEOUT_US * U;
    localparam int M0 = POLL_INTERVAL > TO ? POLL_INTERVAL : TO;
    localparam int M  = M0 > 4 * U ? M0 : 4 * U;
    localparam int CW = $clog2(M + 1);
    localparam logic [CW-1:0] POLL_LAST = CW'(POLL_INTERVAL - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(4 * U - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(3 * U - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(2 * U - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TO - 1);
    localparam logic [CW-1:0] SHORT     = CW'(U);
    localparam logic [CW-1:0] LONG      = CW'(3 * U);
    localparam logic [7:0]    CMD       = 8'h01;

    typedef enum logic [2:0] {IDLE, TX, WAIT_RX, RX, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    bits, bits_n;
    logic [31:0]   shift, shift_n, buttons_n;
    logic          s1, s2, s_prev, fall;
    logic          drive_low_n, valid_n, connected_n;

    assign fall = s_prev & ~s2;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bits      <= '0;
            shift     <= '0;
            s1        <= 1'b1;
            s2        <= 1'b1;
            s_prev    <= 1'b1;
            drive_low <= 1'b0;
            buttons   <= '0;
            valid     <= 1'b0;
            connected <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bits      <= bits_n;
            shift     <= shift_n;
            s1        <= data_in;
            s2        <= s1;
            s_prev    <= s2;
            drive_low <= drive_low_n;
            buttons   <= buttons_n;
            valid     <= valid_n;
            connected <= connected_n;
        end
    end

    // cnt times the current phase; in RX it runs from the latest falling edge so it serves both sampling and timeout
    always_comb begin
        state_n     = state;
        cnt_n       = cnt + 1'b1;
        bits_n      = bits;
        shift_n     = shift;
        buttons_n   = buttons;
        valid_n     = 1'b0;
        connected_n = connected;
        case (state)
            IDLE: if (cnt == POLL_LAST) begin
                state_n = TX;
                cnt_n   = '0;
                bits_n  = '0;
            end
            TX: if (cnt == ((bits == 5'd8) ? STOP_LAST : BIT_LAST)) begin
                cnt_n  = '0;
                bits_n = bits + 1'b1;
                if (bits == 5'd8) state_n = WAIT_RX;
            end
            WAIT_RX: if (fall) begin
                state_n = RX;
                cnt_n   = '0;
                bits_n  = '0;
            end else if (cnt == TO_LAST) begin
                state_n     = IDLE;
                cnt_n       = '0;
                connected_n = 1'b0;
            end
            RX: if (fall) begin
                cnt_n = '0;
            end else if (cnt == HALF_LAST) begin
                shift_n = {shift[30:0], s2};
                bits_n  = bits + 1'b1;
                if (bits == 5'd31) begin
                    state_n = STOP;
                    cnt_n   = '0;
                end
            end else if (cnt == TO_LAST) begin
                state_n     = IDLE;
                cnt_n       = '0;
                connected_n = 1'b0;
            end
            STOP: if (cnt == HALF_LAST) begin
                state_n     = IDLE;
                cnt_n       = '0;
                buttons_n   = shift;
                valid_n     = 1'b1;
                connected_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // bit index 8 is the stop bit, which shares the short low time of a '1'
        drive_low_n = (state_n == TX) &&
                      (cnt_n < (((bits_n == 5'd8) || CMD[3'd7 - bits_n[2:0]]) ? SHORT : LONG));
    end
endmodule
